// File: rtl/y86_pkg.sv
// Shared Y86 execute-stage constants: ALU operation codes and data width.
package y86_pkg;

    localparam int DATA_W = 64;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

endpackage

// File: rtl/y86_addsub64.sv
// Combinational 64-bit ripple adder/subtractor built from per-bit full adders.
module y86_addsub64
    import y86_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              carry,
    output logic              overflow
);

    logic [DATA_W-1:0] b_eff;
    logic              c;

    assign b_eff = sub ? ~b : b;

    // Carry is walked bit by bit so the chain stays a single variable.
    always_comb begin
        sum = '0;
        c   = sub;
        for (int i = 0; i < DATA_W; i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ c;
            c      = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
        end
        carry = c;
    end

    // Operands of like sign producing a result of the other sign.
    assign overflow = (a[DATA_W-1] == b_eff[DATA_W-1]) &&
                      (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/y86_alu.sv
// Registered 64-bit Y86 ALU: add, sub, and, xor with carry and overflow flags.
module y86_alu
    import y86_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic [1:0]               control,
    input  logic signed [DATA_W-1:0] input1,
    input  logic signed [DATA_W-1:0] input2,
    output logic signed [DATA_W-1:0] alu_out,
    output logic                     alu_carry_out,
    output logic                     alu_overflow_check
);

    logic [DATA_W-1:0] sum;
    logic              carry;
    logic              overflow;
    logic [DATA_W-1:0] res;
    logic              res_carry;
    logic              res_ovf;

    y86_addsub64 u_addsub (
        .a        (input1),
        .b        (input2),
        .sub      (control == ALU_SUB),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    always_comb begin
        res       = sum;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        unique case (control)
            ALU_ADD, ALU_SUB: begin
                res       = sum;
                res_carry = carry;
                res_ovf   = overflow;
            end
            ALU_AND: res = input1 & input2;
            ALU_XOR: res = input1 ^ input2;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_out            <= '0;
            alu_carry_out      <= 1'b0;
            alu_overflow_check <= 1'b0;
        end else begin
            alu_out            <= res;
            alu_carry_out      <= res_carry;
            alu_overflow_check <= res_ovf;
        end
    end

endmodule

// File: tb/tb_y86_alu.sv
// Self-checking bench for y86_alu: directed cases plus random ops vs. arithmetic model.
module tb_y86_alu;

    logic        clock;
    logic        reset;
    logic [1:0]  control;
    logic signed [63:0] input1;
    logic signed [63:0] input2;
    logic signed [63:0] alu_out;
    logic        alu_carry_out;
    logic        alu_overflow_check;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_out;
    logic        exp_c;
    logic        exp_v;

    y86_alu dut (
        .clock              (clock),
        .reset              (reset),
        .control            (control),
        .input1             (input1),
        .input2             (input2),
        .alu_out            (alu_out),
        .alu_carry_out      (alu_carry_out),
        .alu_overflow_check (alu_overflow_check)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: true-width arithmetic, flags from range checks.
    task automatic model(input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic rst,
                         output logic [63:0] r, output logic c,
                         output logic v);
        logic [64:0] u;
        logic signed [64:0] s;
        r = '0; c = 1'b0; v = 1'b0;
        if (!rst) begin
            case (op)
                2'd0: begin
                    u = {1'b0, a} + {1'b0, b};
                    r = u[63:0];
                    c = u[64];
                    s = $signed({a[63], a}) + $signed({b[63], b});
                    v = (s > 65'sd9223372036854775807) ||
                        (s < -65'sd9223372036854775808);
                end
                2'd1: begin
                    r = a - b;
                    c = (a >= b);
                    s = $signed({a[63], a}) - $signed({b[63], b});
                    v = (s > 65'sd9223372036854775807) ||
                        (s < -65'sd9223372036854775808);
                end
                2'd2: r = a & b;
                default: r = a ^ b;
            endcase
        end
    endtask

    task automatic check(input string tag);
        total++;
        assert (alu_out === exp_out) else begin
            bad++;
            $error("FAIL %s out: got=%h want=%h", tag, alu_out, exp_out);
        end
        total++;
        assert (alu_carry_out === exp_c) else begin
            bad++;
            $error("FAIL %s carry: got=%b want=%b", tag, alu_carry_out, exp_c);
        end
        total++;
        assert (alu_overflow_check === exp_v) else begin
            bad++;
            $error("FAIL %s ovf: got=%b want=%b", tag, alu_overflow_check, exp_v);
        end
    endtask

    // One cycle: drive while clock is low, sample 1 time unit after the edge.
    task automatic step(input string tag, input logic rst, input logic [1:0] op,
                        input logic [63:0] a, input logic [63:0] b);
        @(negedge clock);
        reset   = rst;
        control = op;
        input1  = a;
        input2  = b;
        model(op, a, b, rst, exp_out, exp_c, exp_v);
        @(posedge clock);
        #1;
        check(tag);
    endtask

    initial begin
        reset   = 1'b1;
        control = 2'd0;
        input1  = '0;
        input2  = '0;

        step("reset0", 1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        step("reset1", 1'b1, 2'd1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000);

        step("add_ovf", 1'b0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        step("add_carry", 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        step("sub_pos", 1'b0, 2'd1, 64'd10, 64'd3);
        step("sub_neg", 1'b0, 2'd1, 64'd3, 64'd10);
        step("sub_ovf", 1'b0, 2'd1, 64'h8000_0000_0000_0000, 64'd1);
        step("and", 1'b0, 2'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        step("xor", 1'b0, 2'd3, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);

        // Input changes between edges must not disturb held outputs.
        #2;
        control = 2'd0;
        input1  = 64'd99;
        input2  = 64'd1;
        #1;
        check("hold");

        step("b2b_add", 1'b0, 2'd0, 64'd100, 64'd23);
        step("b2b_sub", 1'b0, 2'd1, 64'd100, 64'd23);
        step("b2b_xor", 1'b0, 2'd3, 64'd100, 64'd23);
        step("b2b_and", 1'b0, 2'd2, 64'd100, 64'd23);

        step("rst_prio", 1'b1, 2'd0, 64'd5, 64'd6);
        step("after_rst", 1'b0, 2'd0, 64'd5, 64'd6);

        for (int i = 0; i < 300; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            logic [1:0]  op;
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) b = a;
            if ($urandom_range(0, 7) == 0) a[63:1] = {63{a[63]}} ^ 63'h0;
            step("rand", ($urandom_range(0, 19) == 0), op, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
